// File: rtl/tpu_package.sv
// Shared TPU types and constants.
//   decoded_instr_t : decoded instruction fields seen by the fetch units
//   wfetch_state_t  : weight fetch control FSM states
//   calc_num_tiles  : number of MUL_SIZE x MUL_SIZE weight tiles of an instruction
package tpu_package;

  localparam int MUL_SIZE   = 32;
  localparam int DIM_W      = 16;
  localparam int TILE_CNT_W = 10;

  typedef struct packed {
    logic [1:0]       MAC_op;
    logic [DIM_W-1:0] U_dim;
    logic [DIM_W-1:0] ITER_dim;
  } decoded_instr_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BANK,
    ISSUE,
    DRAIN,
    DONE
  } wfetch_state_t;

  // Tile count is deliberately truncated to TILE_CNT_W bits.
  function automatic logic [TILE_CNT_W-1:0] calc_num_tiles(
    input logic [DIM_W-1:0] u_dim,
    input logic [DIM_W-1:0] iter_dim
  );
    logic [DIM_W-1:0] u_tiles;
    logic [DIM_W-1:0] i_tiles;
    u_tiles = u_dim >> $clog2(MUL_SIZE);
    i_tiles = iter_dim >> $clog2(MUL_SIZE);
    return TILE_CNT_W'(u_tiles * i_tiles);
  endfunction

endpackage

// File: rtl/weight_fetch_control_unit_bank_tracker.sv
// Two-bank weight staging buffer occupancy tracker.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   set_tile_i       : producer finished filling the write-side bank
//   release_tile_i   : consumer finished with the read-side bank
//   bank_full_o      : per-bank full flags
//   wr_bank_o        : bank the producer fills next
//   rd_bank_o        : bank the consumer reads
//   protocol_err_o   : sticky, release seen while the read-side bank was empty
module weight_bank_tracker (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_tile_i,
  input  logic       release_tile_i,
  output logic [1:0] bank_full_o,
  output logic       wr_bank_o,
  output logic       rd_bank_o,
  output logic       protocol_err_o
);

  logic       release_ok;
  logic [1:0] bank_full_d;

  assign release_ok = release_tile_i & bank_full_o[rd_bank_o];

  // A set and a release in the same cycle always hit different banks, so
  // both updates are applied to the same next-state vector.
  always_comb begin
    bank_full_d = bank_full_o;
    if (set_tile_i) bank_full_d[wr_bank_o] = 1'b1;
    if (release_ok) bank_full_d[rd_bank_o] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_full_o    <= '0;
      wr_bank_o      <= 1'b0;
      rd_bank_o      <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      bank_full_o <= bank_full_d;
      if (set_tile_i) wr_bank_o <= ~wr_bank_o;
      if (release_ok) rd_bank_o <= ~rd_bank_o;
      if (release_tile_i && !bank_full_o[rd_bank_o]) protocol_err_o <= 1'b1;
    end
  end

endmodule

// File: rtl/weight_fetch_control_unit.sv
// Weight fetch control: streams 32x32 weight tiles from weight memory into a
// two-bank staging buffer and runs the weight-ready handshake with compute.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   instruction_i/_valid_i    : decoded instruction (MAC_op, U_dim, ITER_dim)
//   weight_base_addr_i        : first weight row address, sampled on accept
//   instr_accept_o            : pulse, instruction latched
//   wmem_rd_en_o/wmem_addr_o  : weight memory row read (data 1 cycle later)
//   wmem_rd_data_i            : weight memory read data
//   wbuf_wr_en_o/bank/row/data: staging buffer write port
//   next_weight_tile_i        : compute consumed the current tile
//   compute_weights_rdy_o     : compute-side bank holds a full tile
//   compute_bank_o            : bank compute should read
//   fetch_done_o              : pulse, last tile of the instruction written
//   protocol_err_o            : sticky, release while compute bank empty
module weight_fetch_control_unit
  import tpu_package::*;
#(
  parameter int MUL_SIZE = tpu_package::MUL_SIZE,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  decoded_instr_t               instruction_i,
  input  logic                         instruction_valid_i,
  input  logic [ADDR_W-1:0]            weight_base_addr_i,
  output logic                         instr_accept_o,
  output logic                         wmem_rd_en_o,
  output logic [ADDR_W-1:0]            wmem_addr_o,
  input  logic [MUL_SIZE*DATA_W-1:0]   wmem_rd_data_i,
  output logic                         wbuf_wr_en_o,
  output logic                         wbuf_bank_o,
  output logic [$clog2(MUL_SIZE)-1:0]  wbuf_row_o,
  output logic [MUL_SIZE*DATA_W-1:0]   wbuf_data_o,
  input  logic                         next_weight_tile_i,
  output logic                         compute_weights_rdy_o,
  output logic                         compute_bank_o,
  output logic                         fetch_done_o,
  output logic                         protocol_err_o
);

  localparam int ROW_W = $clog2(MUL_SIZE);

  wfetch_state_t           state;
  logic [TILE_CNT_W-1:0]   tile_cnt;
  logic [TILE_CNT_W-1:0]   num_tiles_q;
  logic [TILE_CNT_W-1:0]   num_tiles_in;
  logic [ROW_W-1:0]        row;
  logic [ADDR_W-1:0]       base_q;
  logic [1:0]              bank_full;
  logic                    wr_bank;
  logic                    rd_bank;
  logic                    set_tile;
  logic                    unused_mac_bit;

  assign unused_mac_bit = instruction_i.MAC_op[0];
  assign num_tiles_in   = calc_num_tiles(instruction_i.U_dim, instruction_i.ITER_dim);
  assign set_tile       = (state == DRAIN);

  assign wbuf_data_o           = wmem_rd_data_i;
  assign compute_weights_rdy_o = bank_full[rd_bank];
  assign compute_bank_o        = rd_bank;

  weight_bank_tracker u_bank_tracker (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .set_tile_i     (set_tile),
    .release_tile_i (next_weight_tile_i),
    .bank_full_o    (bank_full),
    .wr_bank_o      (wr_bank),
    .rd_bank_o      (rd_bank),
    .protocol_err_o (protocol_err_o)
  );

  // Read strobe and address are registered one state ahead so that they are
  // asserted exactly during the ISSUE cycles; the address then just counts up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      tile_cnt       <= '0;
      num_tiles_q    <= '0;
      row            <= '0;
      base_q         <= '0;
      instr_accept_o <= 1'b0;
      wmem_rd_en_o   <= 1'b0;
      wmem_addr_o    <= '0;
      fetch_done_o   <= 1'b0;
      wbuf_wr_en_o   <= 1'b0;
      wbuf_row_o     <= '0;
      wbuf_bank_o    <= 1'b0;
    end else begin
      instr_accept_o <= 1'b0;
      fetch_done_o   <= 1'b0;
      wbuf_wr_en_o   <= wmem_rd_en_o;
      wbuf_row_o     <= row;
      wbuf_bank_o    <= wr_bank;
      case (state)
        IDLE: begin
          if (instruction_valid_i && instruction_i.MAC_op[1]) begin
            base_q         <= weight_base_addr_i;
            num_tiles_q    <= num_tiles_in;
            tile_cnt       <= '0;
            instr_accept_o <= 1'b1;
            if (num_tiles_in == '0) begin
              state        <= DONE;
              fetch_done_o <= 1'b1;
            end else begin
              state <= WAIT_BANK;
            end
          end
        end
        WAIT_BANK: begin
          if (!bank_full[wr_bank]) begin
            state        <= ISSUE;
            row          <= '0;
            wmem_rd_en_o <= 1'b1;
            wmem_addr_o  <= base_q + ADDR_W'(tile_cnt) * ADDR_W'(MUL_SIZE);
          end
        end
        ISSUE: begin
          row <= row + ROW_W'(1);
          if (row == ROW_W'(MUL_SIZE - 1)) begin
            wmem_rd_en_o <= 1'b0;
            state        <= DRAIN;
          end else begin
            wmem_addr_o <= wmem_addr_o + ADDR_W'(1);
          end
        end
        DRAIN: begin
          tile_cnt <= tile_cnt + TILE_CNT_W'(1);
          if (tile_cnt + TILE_CNT_W'(1) == num_tiles_q) begin
            state        <= DONE;
            fetch_done_o <= 1'b1;
          end else begin
            state <= WAIT_BANK;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_control_unit.sv
module tb_weight_fetch_control_unit;
  import tpu_package::*;

  localparam int MS = 32;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int RW = 5;
  localparam int DB = MS * DW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
    logic          bank;
  } xfer_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rst_q = 1'b1;
  decoded_instr_t instr = '0;
  logic           instr_valid = 1'b0;
  logic [AW-1:0]  wbase = '0;
  logic           instr_accept_o;
  logic           wmem_rd_en_o;
  logic [AW-1:0]  wmem_addr_o;
  logic [DB-1:0]  wmem_rd_data = '0;
  logic           wbuf_wr_en_o;
  logic           wbuf_bank_o;
  logic [RW-1:0]  wbuf_row_o;
  logic [DB-1:0]  wbuf_data_o;
  logic           next_tile = 1'b0;
  logic           compute_weights_rdy_o;
  logic           compute_bank_o;
  logic           fetch_done_o;
  logic           protocol_err_o;

  int total = 0;
  int bad = 0;

  // reference model state
  xfer_t read_q[$];
  xfer_t write_q[$];
  bit    accept_q[$];
  int    done_q[$];
  int    gtile = 0;
  int    cum_writes = 0;
  int    writes_seen = 0;
  int    comp_cnt = 0;
  int    rel_cnt = 0;
  logic  err_exp = 1'b0;

  int cons_mode = 0;
  bit pulse_req = 1'b0;

  weight_fetch_control_unit #(.MUL_SIZE(MS), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .instruction_i         (instr),
    .instruction_valid_i   (instr_valid),
    .weight_base_addr_i    (wbase),
    .instr_accept_o        (instr_accept_o),
    .wmem_rd_en_o          (wmem_rd_en_o),
    .wmem_addr_o           (wmem_addr_o),
    .wmem_rd_data_i        (wmem_rd_data),
    .wbuf_wr_en_o          (wbuf_wr_en_o),
    .wbuf_bank_o           (wbuf_bank_o),
    .wbuf_row_o            (wbuf_row_o),
    .wbuf_data_o           (wbuf_data_o),
    .next_weight_tile_i    (next_tile),
    .compute_weights_rdy_o (compute_weights_rdy_o),
    .compute_bank_o        (compute_bank_o),
    .fetch_done_o          (fetch_done_o),
    .protocol_err_o        (protocol_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [DB-1:0] mem_word(input logic [AW-1:0] a);
    logic [DB-1:0] w;
    for (int i = 0; i < DB / 32; i++)
      w[i*32 +: 32] = {a, ~a} ^ (32'h9E3779B9 * 32'(i + 1));
    return w;
  endfunction

  // weight memory: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    if (wmem_rd_en_o) wmem_rd_data <= mem_word(wmem_addr_o);
    else              wmem_rd_data <= {8{$urandom}};
  end

  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string nm, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=event exp=none", nm);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin : mon
    xfer_t e;
    logic  fill;
    fill = 1'b0;
    if (rst_q) begin
      chk("reset_outs", DB'({instr_accept_o, wmem_rd_en_o, wmem_addr_o, wbuf_wr_en_o,
                             wbuf_bank_o, wbuf_row_o, compute_weights_rdy_o,
                             compute_bank_o, fetch_done_o, protocol_err_o}), '0);
      read_q.delete();
      write_q.delete();
      accept_q.delete();
      done_q.delete();
      gtile = 0; cum_writes = 0; writes_seen = 0;
      comp_cnt = 0; rel_cnt = 0; err_exp = 1'b0;
    end else begin
      chk("rdy", DB'(compute_weights_rdy_o), DB'(comp_cnt != rel_cnt));
      chk("compute_bank", DB'(compute_bank_o), DB'(rel_cnt[0]));
      chk("protocol_err", DB'(protocol_err_o), DB'(err_exp));
      if (wmem_rd_en_o) begin
        if (read_q.size() == 0) miss("unexpected_read");
        else begin
          e = read_q.pop_front();
          chk("rd_addr", DB'(wmem_addr_o), DB'(e.addr));
          if (e.row == '0) chk("fetch_while_banks_full", DB'((comp_cnt - rel_cnt) >= 2), '0);
        end
      end
      if (wbuf_wr_en_o) begin
        if (write_q.size() == 0) miss("unexpected_write");
        else begin
          e = write_q.pop_front();
          chk("wr_bank", DB'(wbuf_bank_o), DB'(e.bank));
          chk("wr_row", DB'(wbuf_row_o), DB'(e.row));
          chk("wr_data", wbuf_data_o, mem_word(e.addr));
          writes_seen++;
          if (e.row == RW'(MS - 1)) fill = 1'b1;
        end
      end
      if (instr_accept_o) begin
        if (accept_q.size() == 0) miss("unexpected_accept");
        else void'(accept_q.pop_front());
      end
      if (fetch_done_o) begin
        if (done_q.size() == 0) miss("unexpected_done");
        else chk("done_after_writes", DB'(writes_seen), DB'(done_q.pop_front()));
      end
      if (next_tile) begin
        if (comp_cnt != rel_cnt) rel_cnt++;
        else err_exp = 1'b1;
      end
      if (fill) comp_cnt++;
    end
  end

  // consumer
  initial begin
    forever begin
      logic nw;
      @(posedge clk);
      #1;
      nw = 1'b0;
      if (pulse_req) begin
        nw = 1'b1;
        pulse_req = 1'b0;
      end else if (cons_mode == 1) begin
        nw = compute_weights_rdy_o && ($urandom_range(0, 2) == 0);
      end else if (cons_mode == 2) begin
        if (wbuf_wr_en_o && wbuf_row_o == RW'(MS - 1) && compute_weights_rdy_o) begin
          nw = 1'b1;
          cons_mode = 0;
        end
      end
      next_tile = nw;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic send_instr(input logic [1:0] mac, input logic [15:0] u, input logic [15:0] it,
                            input logic [AW-1:0] base);
    int  n;
    bit  got;
    xfer_t e;
    instr.MAC_op   = mac;
    instr.U_dim    = u;
    instr.ITER_dim = it;
    wbase          = base;
    if (mac[1]) begin
      accept_q.push_back(1'b1);
      instr_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        cyc(1);
        if (instr_accept_o) begin
          got = 1'b1;
          break;
        end
      end
      instr_valid = 1'b0;
      chk("accept_seen", DB'(got), DB'(1));
      if (got) begin
        n = ((int'(u) >> 5) * (int'(it) >> 5)) % 1024;
        for (int t = 0; t < n; t++) begin
          for (int r = 0; r < MS; r++) begin
            e.addr = AW'(int'(base) + t * MS + r);
            e.row  = RW'(r);
            e.bank = gtile[0];
            read_q.push_back(e);
            write_q.push_back(e);
          end
          gtile++;
        end
        cum_writes += n * MS;
        done_q.push_back(cum_writes);
      end
    end else begin
      instr_valid = 1'b1;
      cyc(3);
      instr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int bound);
    bit got;
    got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (fetch_done_o) begin
        got = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("done_seen", DB'(got), DB'(1));
  endtask

  initial begin
    logic [15:0] dims [6];
    bit hit;
    dims = '{16'd0, 16'd16, 16'd32, 16'd48, 16'd64, 16'd96};

    do_reset();

    // release with both banks empty: sticky error, no bank change
    pulse_req = 1'b1;
    cyc(6);
    do_reset();

    // single tile
    cons_mode = 0;
    send_instr(2'b10, 16'd32, 16'd32, 16'h0100);
    wait_done(200);
    cyc(3);
    pulse_req = 1'b1;
    cyc(3);

    // zero tiles, and a non-MAC instruction that must be ignored
    send_instr(2'b11, 16'd16, 16'd64, 16'h0500);
    wait_done(20);
    cyc(2);
    send_instr(2'b01, 16'd32, 16'd32, 16'h0600);
    cyc(4);

    // four tiles with no consumer: stall, then one release
    send_instr(2'b10, 16'd64, 16'd64, 16'h0200);
    cyc(120);
    pulse_req = 1'b1;
    cyc(60);
    cons_mode = 1;
    wait_done(2000);
    cyc(150);
    cons_mode = 0;
    do_reset();

    // release on the same cycle the other bank completes
    cons_mode = 2;
    send_instr(2'b10, 16'd64, 16'd32, 16'h0280);
    wait_done(300);
    cons_mode = 0;
    cyc(3);
    pulse_req = 1'b1;
    cyc(3);
    do_reset();

    // reset while row 10 is being read
    send_instr(2'b10, 16'd64, 16'd32, 16'h0300);
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (wmem_rd_en_o && wmem_addr_o == 16'h030A) begin
        hit = 1'b1;
        break;
      end
    end
    chk("row10_seen", DB'(hit), DB'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(2);
    cons_mode = 1;
    send_instr(2'b10, 16'd32, 16'd32, 16'h0040);
    wait_done(400);

    // random instructions with a random consumer, prefetching back to back
    for (int i = 0; i < 10; i++) begin
      logic [1:0] mac;
      mac = 2'($urandom_range(0, 3));
      send_instr(mac, dims[$urandom_range(0, 5)], dims[$urandom_range(0, 5)], 16'($urandom));
      if (mac[1]) wait_done(4000);
    end
    cyc(250);
    cons_mode = 0;
    cyc(3);

    chk("reads_pending", DB'(read_q.size()), '0);
    chk("writes_pending", DB'(write_q.size()), '0);
    chk("accepts_pending", DB'(accept_q.size()), '0);
    chk("dones_pending", DB'(done_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
